// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and sequencing controller for the 5-stage pipeline
// (IF, ID, EX, MEM, WB).
//
// Purpose:
//   Produces per-stage stall/clear strobes, a one-cycle PC redirect pulse on
//   exception accept, and the registered branch-delay-slot flag for stage_id.
//   Arbitration in RUN, highest first: exception, memory wait, load-use
//   interlock, fetch wait. Multi-cycle flushes and load-use bubbles are
//   sequenced by a small FSM (RUN / FLUSH / BUBBLE).
//
// Parameters:
//   FLUSH_CYCLES      cycles the ID/EX/MEM clears are held after an exception (>=1)
//   LOAD_USE_BUBBLES  bubbles inserted into the ID output per load-use hazard (>=1)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_instr_rs, if_instr_rt      source register fields of the IF/ID instruction
//   if_is_branch                  IF/ID instruction is a branch/jump
//   ex_mem_read, ex_wb_reg_addr   EX instruction is a load / its destination
//   if_busy, mem_busy             fetch / memory still waiting this cycle
//   exc_req                       MEM commits an exception or ERET this cycle
//   stall_if..stall_mem           hold stage outputs
//   clear_id..clear_mem           stage emits a bubble on the next edge
//   in_branch_delay_slot          registered delay-slot flag
//   pc_redirect                   IF loads the exception/EPC target
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   Adds 32-bit wrapping counters perf_stall_mem, perf_load_use, perf_flush.

module pipeline_ctrl #(
  parameter int FLUSH_CYCLES     = 2,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  if_instr_rs,
  input  logic [4:0]  if_instr_rt,
  input  logic        if_is_branch,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_wb_reg_addr,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        exc_req,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        clear_id,
  output logic        clear_ex,
  output logic        clear_mem,
  output logic        in_branch_delay_slot,
  output logic        pc_redirect
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_mem,
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_flush
`endif
);

  // Counter widths only need to hold PARAM-2; keep at least one bit.
  localparam int FC_W = (FLUSH_CYCLES > 2)     ? $clog2(FLUSH_CYCLES)     : 1;
  localparam int BC_W = (LOAD_USE_BUBBLES > 2) ? $clog2(LOAD_USE_BUBBLES) : 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [BC_W-1:0] bub_cnt, bub_cnt_nxt;
  logic            load_use;
  logic            exc_accept;

  // Register 0 is hardwired to zero, so a load targeting it never interlocks.
  assign load_use = ex_mem_read && (ex_wb_reg_addr != 5'd0) &&
                    ((ex_wb_reg_addr == if_instr_rs) ||
                     (ex_wb_reg_addr == if_instr_rt));

  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    clear_id      = 1'b0;
    clear_ex      = 1'b0;
    clear_mem     = 1'b0;
    pc_redirect   = 1'b0;
    exc_accept    = 1'b0;
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    bub_cnt_nxt   = bub_cnt;

    unique case (state)
      ST_RUN, ST_BUBBLE: begin
        if (exc_req) begin
          // Exception wins over everything, including a pending memory wait:
          // MEM is squashed rather than stalled.
          exc_accept  = 1'b1;
          pc_redirect = 1'b1;
          clear_id    = 1'b1;
          clear_ex    = 1'b1;
          clear_mem   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 2);
          end else begin
            state_nxt = ST_RUN;
          end
        end else if (mem_busy) begin
          // Freezes the whole pipe; bub_cnt is left untouched.
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
        end else if (state == ST_BUBBLE) begin
          stall_if = 1'b1;
          clear_id = 1'b1;
          if (bub_cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            bub_cnt_nxt = bub_cnt - BC_W'(1);
          end
        end else if (load_use) begin
          // The first bubble is this cycle; the FSM supplies the rest.
          stall_if = 1'b1;
          clear_id = 1'b1;
          if (LOAD_USE_BUBBLES > 1) begin
            state_nxt   = ST_BUBBLE;
            bub_cnt_nxt = BC_W'(LOAD_USE_BUBBLES - 2);
          end
        end else if (if_busy) begin
          stall_if = 1'b1;
          clear_id = 1'b1;
        end
      end
      ST_FLUSH: begin
        // exc_req and mem_busy are deliberately ignored while flushing.
        clear_id  = 1'b1;
        clear_ex  = 1'b1;
        clear_mem = 1'b1;
        if (flush_cnt == '0) begin
          state_nxt = ST_RUN;
        end else begin
          flush_cnt_nxt = flush_cnt - FC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // Reset presents a fully cleared, unstalled pipe.
    if (rst) begin
      stall_if      = 1'b0;
      stall_id      = 1'b0;
      stall_ex      = 1'b0;
      stall_mem     = 1'b0;
      clear_id      = 1'b1;
      clear_ex      = 1'b1;
      clear_mem     = 1'b1;
      pc_redirect   = 1'b0;
      exc_accept    = 1'b0;
      state_nxt     = ST_RUN;
      flush_cnt_nxt = '0;
      bub_cnt_nxt   = '0;
    end
  end

  // State register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      bub_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      bub_cnt   <= bub_cnt_nxt;
    end
  end

  // Delay-slot flag boundary: only moves when ID actually consumes the
  // IF/ID instruction, so stalls and bubbles leave it intact.
  always_ff @(posedge clk) begin
    if (rst || exc_accept) begin
      in_branch_delay_slot <= 1'b0;
    end else if (!stall_id && !clear_id) begin
      in_branch_delay_slot <= if_is_branch;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic lu_bubble;

  // A load-use bubble cycle: the RUN-state hit itself, or a BUBBLE cycle
  // that is neither preempted by an exception nor frozen by memory.
  assign lu_bubble = !rst && !exc_req && !mem_busy &&
                     (((state == ST_RUN) && load_use) || (state == ST_BUBBLE));

  // Performance counter boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_mem <= '0;
      perf_load_use  <= '0;
      perf_flush     <= '0;
    end else begin
      if (stall_mem)  perf_stall_mem <= perf_stall_mem + 32'd1;
      if (lu_bubble)  perf_load_use  <= perf_load_use + 32'd1;
      if (exc_accept) perf_flush     <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage stall/clear strobes and the registered branch-delay-slot flag consumed by stage_id.
- Arbitrates between exception flush, memory wait, load-use interlock and instruction-fetch wait.
- Runs a small FSM for multi-cycle flushes and load-use bubbles.

Parameters:
- FLUSH_CYCLES, 2, cycles clear_id/clear_ex/clear_mem are held after an exception is accepted (>=1).
- LOAD_USE_BUBBLES, 1, bubbles inserted into ID output per load-use hazard (>=1).

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- if_instr_rs  in  5  rs field of instruction held in IF/ID latch
- if_instr_rt  in  5  rt field of instruction held in IF/ID latch
- if_is_branch  in  1  instruction in IF/ID latch is a branch/jump (any BRANCH_ opt other than NONE)
- ex_mem_read  in  1  instruction in EX is a load (MEM_OPT_IS_READ)
- ex_wb_reg_addr  in  5  writeback register of instruction in EX
- if_busy  in  1  fetch not yet complete this cycle
- mem_busy  in  1  MEM stage waiting on memory/TLB
- exc_req  in  1  MEM stage commits an exception or ERET this cycle
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold stage outputs
- clear_id, clear_ex, clear_mem  out  1 each  stage emits bubble on next edge
- in_branch_delay_slot  out  1  registered; IF/ID instruction follows a branch/jump
- pc_redirect  out  1  one-cycle pulse: IF loads exception/EPC target

Behaviour:
- Outputs are combinational from state and inputs, except in_branch_delay_slot (flop).
- While rst=1: all stall_*=0, all clear_*=1, pc_redirect=0. Takes effect at the clock edge: in_branch_delay_slot<=0, state<=RUN, counters<=0.
- FSM states:
  - RUN: normal operation.
  - FLUSH: counter flush_cnt counts down.
  - BUBBLE: counter bub_cnt counts down.
- Priority within RUN, highest first:
  - (1) exc_req: pc_redirect=1, clear_id=clear_ex=clear_mem=1, all stalls 0. in_branch_delay_slot<=0. If FLUSH_CYCLES>1: state<=FLUSH, flush_cnt<=FLUSH_CYCLES-2.
  - (2) mem_busy: all stall_*=1, no clears.
  - (3) load-use: ex_mem_read && ex_wb_reg_addr!=0 && (ex_wb_reg_addr==if_instr_rs || ==if_instr_rt). Drive stall_if=1, clear_id=1, other stalls 0. If LOAD_USE_BUBBLES>1: state<=BUBBLE, bub_cnt<=LOAD_USE_BUBBLES-2.
  - (4) if_busy: stall_if=1, clear_id=1.
  - (5) none of the above: all stall_* and clear_* are 0.
- FLUSH state:
  - clear_id/ex/mem=1, pc_redirect=0; exc_req ignored; mem_busy ignored.
  - Return to RUN when flush_cnt==0, else decrement.
- BUBBLE state:
  - exc_req preempts: behaves as RUN case (1) and overrides BUBBLE.
  - mem_busy freezes bub_cnt and asserts all stalls.
  - Otherwise stall_if=1, clear_id=1; return to RUN when bub_cnt==0, else decrement.
- Delay-slot flag:
  - Updated only when ID consumes an instruction: stall_id=0 && clear_id=0 && not rst. Update is in_branch_delay_slot<=if_is_branch.
  - Held unchanged during stalls and bubbles; forced to 0 on exception accept.
- Simultaneous exc_req and mem_busy: exception wins; MEM is squashed by clear_mem.
- Register 0 never creates a load-use hazard.
- rst asserted mid-FLUSH or mid-BUBBLE returns to RUN at the next edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, adds three output ports, each 32 bits: perf_stall_mem, perf_load_use, perf_flush.
  - perf_stall_mem increments on each mem_busy stall cycle.
  - perf_load_use increments on each load-use bubble cycle.
  - perf_flush increments on each exception accept.
  - All wrap modulo 2^32 and reset to 0 on rst.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_wb_reg_addr=5, if_instr_rt=5 for 1 cycle (defaults) -> stall_if=1, clear_id=1 that cycle; next cycle all 0. Repeat with addr 0 -> no stall.
- LOAD_USE_BUBBLES=3 load-use hit -> stall_if/clear_id high exactly 3 cycles. With mem_busy=1 during cycle 2 -> all stalls high, bubble count resumes after, total bubble cycles still 3.
- exc_req pulse with FLUSH_CYCLES=2 -> pc_redirect=1 for 1 cycle, clear_id/ex/mem=1 for 2 cycles. A second exc_req in cycle 2 is ignored.
- exc_req && mem_busy in same cycle -> pc_redirect=1, clear_mem=1, stall_mem=0.
- Delay slot: if_is_branch=1 consumed -> in_branch_delay_slot=1 next cycle. It holds through 2 if_busy cycles, then drops to 0 after a non-branch is consumed. An exception clears it immediately.
- rst asserted during FLUSH -> next cycle state RUN, clears from reset only. With PIPE_CTRL_PERF_EN: perf_flush=0 after reset, =1 after one exception.
